// File: rtl/arb_mux_n.sv
// N-channel, W-bit stream multiplexer with valid/ready handshakes, a registered
// output stage, and either fixed-select or round-robin arbitration.
module arb_mux_n #(
  parameter int N = 3,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0]  chan [N];
  logic [W-1:0]  out_data_reg;
  logic [SW-1:0] out_src_reg;
  logic          out_valid_reg;
  logic [SW-1:0] rr_ptr_reg;
  logic [SW-1:0] rr_ptr_next;
  logic          load;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic          transfer;
  int            scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign chan[gi] = in_data[gi*W +: W];
    end
  endgenerate

  assign load     = !out_valid_reg || out_ready;
  assign transfer = load && grant_valid;

  // An out-of-range sel never matches any channel, so it yields no grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = int'(rr_ptr_reg) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (!grant_valid && in_valid[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = SW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && transfer) in_ready[grant_idx] = 1'b1;
  end

  assign rr_ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      if (transfer) begin
        out_data_reg  <= chan[grant_idx];
        out_src_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (mode) rr_ptr_reg <= rr_ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed vector bench for arb_mux_n (N=3, W=8): table of per-cycle vectors
// plus a hand-written mid-stream reset sequence.
module tb_arb_mux_n;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  arb_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   iv;
    logic [N*W-1:0] data;
    logic           ordy;
    logic [N-1:0]   exp_ir;
    logic           exp_ov;
    logic [W-1:0]   exp_od;
    logic [SW-1:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic [SW-1:0] s, input logic [N-1:0] iv,
                     input logic [N*W-1:0] d, input logic ordy, input logic [N-1:0] ir,
                     input logic ov, input logic [W-1:0] od, input logic [SW-1:0] src);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.data = d; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_src = src;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; in_ready is sampled
  // mid-cycle and the registered outputs 1 unit after the next edge.
  task automatic run_vec(input vec_t v, input int idx);
    mode = v.mode; sel = v.sel; in_valid = v.iv; in_data = v.data; out_ready = v.ordy;
    #2;
    check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'(v.exp_ir));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
    if (v.exp_ov) begin
      check($sformatf("v%0d_out_data", idx), 32'(out_data), 32'(v.exp_od));
      check($sformatf("v%0d_out_src", idx), 32'(out_src), 32'(v.exp_src));
    end
    $display("vec %0d mode=%0d sel=%0d iv=%b ordy=%0d -> in_ready=%b out_valid=%0d out_data=%h out_src=%0d",
             idx, v.mode, v.sel, v.iv, v.ordy, in_ready, out_valid, out_data, out_src);
  endtask

  localparam logic [N*W-1:0] D0 = {8'hCC, 8'hBB, 8'hAA};

  initial begin
    // fixed select, including out-of-range sel and unselected-valid cases
    add(0, 1, 3'b111, D0, 1, 3'b010, 1, 8'hBB, 1);
    add(0, 3, 3'b111, D0, 1, 3'b000, 0, 8'h00, 0);
    add(0, 0, 3'b110, D0, 1, 3'b000, 0, 8'h00, 0);
    add(0, 2, 3'b100, D0, 1, 3'b100, 1, 8'hCC, 2);
    // round-robin fairness: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++)
      add(1, 0, 3'b111, D0, 1, 3'(1 << (k % 3)), 1, D0[(k % 3)*W +: W], 2'(k % 3));
    // skip and wrap: rr_ptr -> 2, then grant 0, then grant 1
    add(1, 0, 3'b010, D0, 1, 3'b010, 1, 8'hBB, 1);
    add(1, 0, 3'b011, D0, 1, 3'b001, 1, 8'hAA, 0);
    add(1, 0, 3'b011, D0, 1, 3'b010, 1, 8'hBB, 1);
    // idle in both modes; rr_ptr must stay at 2
    add(1, 0, 3'b000, D0, 1, 3'b000, 0, 8'h00, 0);
    add(0, 1, 3'b000, D0, 1, 3'b000, 0, 8'h00, 0);
    add(1, 0, 3'b111, D0, 1, 3'b100, 1, 8'hCC, 2);
    // a mode-0 grant leaves rr_ptr alone
    add(0, 0, 3'b111, D0, 1, 3'b001, 1, 8'hAA, 0);
    add(1, 0, 3'b111, D0, 1, 3'b001, 1, 8'hAA, 0);
    // back-pressure: hold 5A for three cycles while inputs change, then no bubble
    add(0, 0, 3'b001, {8'hCC, 8'hBB, 8'h5A}, 1, 3'b001, 1, 8'h5A, 0);
    add(0, 1, 3'b111, D0, 0, 3'b000, 1, 8'h5A, 0);
    add(1, 0, 3'b111, {8'h11, 8'h22, 8'h33}, 0, 3'b000, 1, 8'h5A, 0);
    add(0, 2, 3'b100, {8'h77, 8'h22, 8'h33}, 0, 3'b000, 1, 8'h5A, 0);
    add(0, 2, 3'b100, {8'h77, 8'h22, 8'h33}, 1, 3'b100, 1, 8'h77, 2);
    add(1, 0, 3'b111, D0, 1, 3'b010, 1, 8'hBB, 1);
    add(1, 0, 3'b111, D0, 0, 3'b000, 1, 8'hBB, 1);

    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 3'b111; in_data = D0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_src", 32'(out_src), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // mid-stream reset while a word is held and rr_ptr is 2
    #4;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_src", 32'(out_src), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_edge_in_ready", 32'(in_ready), 32'd0);
    check("midrst_edge_out_valid", 32'(out_valid), 32'd0);
    $display("mid-stream reset: out_valid=%0d out_data=%h out_src=%0d in_ready=%b",
             out_valid, out_data, out_src, in_ready);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'b001);
    @(posedge clk);
    #1;
    check("postrst_out_valid", 32'(out_valid), 32'd1);
    check("postrst_out_src", 32'(out_src), 32'd0);
    check("postrst_out_data", 32'(out_data), 32'hAA);
    $display("post-reset grant: out_valid=%0d out_data=%h out_src=%0d",
             out_valid, out_data, out_src);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
